// File: rtl/onchip_mem_write_ctrl.sv
// onchip_mem_write_ctrl
// Turns a byte-addressed write command plus a stream of 256-bit beats into
// 256-bit word writes on an on-chip memory port with per-byte enables.
// Build option: define ONCHIP_MEM_WR_UNALIGNED_EN to accept an arbitrary byte
// offset in the start address (adds the realignment shifter, the previous-beat
// register and the FLUSH word). Without it the start address is treated as
// word aligned and every accepted beat is written as-is.
//
// Handshake: a beat transfers on a rising clk edge where write_data_valid_in
// and write_ready_out are both high; ready never depends on valid, and valid
// may drop at any time to insert idle cycles.
module onchip_mem_write_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  output logic         onchip_mem_chip_select,
  output logic         onchip_mem_clk_ena,
  output logic         onchip_mem_write,
  output logic [12:0]  onchip_mem_addr,
  output logic [255:0] onchip_mem_write_data,
  output logic [31:0]  onchip_mem_byteenable,
  input  logic [17:0]  onchip_mem_start_addr_in,
  input  logic [31:0]  to_write_byte_in,
  input  logic         onchip_mem_write_start_in,
  output logic         onchip_mem_write_done_out,
  output logic         busy_out,
  input  logic [255:0] write_data_in,
  input  logic         write_data_valid_in,
  output logic         write_ready_out,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t        state, state_n;
  logic [12:0]   base_q;
  logic [31:0]   beats_q;      // beats required for the command
  logic [31:0]   beat_cnt;     // beats accepted so far (= index of next write)
  logic [31:0]   last_idx_q;   // index of the last memory word written
  logic [4:0]    last_lane_q;  // highest enabled lane in the last word
  logic [4:0]    offset_q;
  logic [4:0]    start_offset;
  logic          accept;
  logic          emit;
  logic [255:0]  emit_data;
  logic [255:0]  stream_data;
  logic [31:0]   be_next;
  logic [4:0]    lane_lo;
  logic [4:0]    lane_hi;
  logic [5:0]    tail_sum;
  logic [31:0]   beats_calc;
  logic [31:0]   words_calc;

`ifdef ONCHIP_MEM_WR_UNALIGNED_EN
  logic          need_flush_q;
  logic [255:0]  prev_q;
  logic [255:0]  flush_data;
  logic [8:0]    prev_shift;

  assign start_offset = onchip_mem_start_addr_in[4:0];
  assign prev_shift   = 9'd256 - {1'b0, offset_q, 3'b000};
  assign flush_data   = prev_q << prev_shift;
  assign stream_data  = flush_data | (write_data_in >> {offset_q, 3'b000});
`else
  logic          unused_offset;

  assign unused_offset = ^onchip_mem_start_addr_in[4:0];
  assign start_offset  = 5'd0;
  assign offset_q      = 5'd0;
  assign stream_data   = write_data_in;
`endif

  // Word counts are split into whole words plus a tail so that no sum of the
  // byte count and offset can overflow 32 bits.
  assign tail_sum   = {1'b0, to_write_byte_in[4:0]} + {1'b0, start_offset};
  assign beats_calc = (to_write_byte_in >> 5) + {31'd0, |to_write_byte_in[4:0]};
  assign words_calc = (to_write_byte_in >> 5) + {31'd0, tail_sum[5]}
                    + {31'd0, |tail_sum[4:0]};

  assign accept                    = write_ready_out & write_data_valid_in;
  assign onchip_mem_clk_ena        = 1'b1;
  assign onchip_mem_write_done_out = (state == DONE);
  assign busy_out                  = (state != IDLE);
  assign dbg_state                 = state;

  // Byte-enable of the word about to be written: lanes from the start offset
  // (first word only) up to the last valid lane (last word only).
  always_comb begin
    lane_lo = (beat_cnt == 32'd0) ? offset_q : 5'd0;
    lane_hi = (beat_cnt == last_idx_q) ? last_lane_q : 5'd31;
    be_next = (32'hFFFF_FFFF >> lane_lo) & ~(32'h7FFF_FFFF >> lane_hi);
  end

  // Next-state, ready and write-request decode.
  always_comb begin
    state_n         = state;
    write_ready_out = 1'b0;
    emit            = 1'b0;
    emit_data       = '0;
    case (state)
      IDLE: begin
        if (onchip_mem_write_start_in)
          state_n = (to_write_byte_in == 32'd0) ? DONE : STREAM;
      end
      STREAM: begin
        write_ready_out = (beat_cnt < beats_q);
        if (write_ready_out && write_data_valid_in) begin
          emit      = 1'b1;
          emit_data = stream_data;
        end else if (!write_ready_out) begin
          // All beats taken; their last write is on the port this cycle.
`ifdef ONCHIP_MEM_WR_UNALIGNED_EN
          if (need_flush_q) begin
            emit      = 1'b1;
            emit_data = flush_data;
            state_n   = FLUSH;
          end else begin
            state_n = DONE;
          end
`else
          state_n = DONE;
`endif
        end
      end
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, command registers and the registered memory port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                  <= IDLE;
      onchip_mem_write       <= 1'b0;
      onchip_mem_chip_select <= 1'b0;
      onchip_mem_addr        <= '0;
      onchip_mem_write_data  <= '0;
      onchip_mem_byteenable  <= '0;
      base_q                 <= '0;
      beats_q                <= '0;
      beat_cnt               <= '0;
      last_idx_q             <= '0;
      last_lane_q            <= '0;
    end else begin
      state                  <= state_n;
      onchip_mem_write       <= emit;
      onchip_mem_chip_select <= emit;
      if (emit) begin
        onchip_mem_addr       <= base_q + beat_cnt[12:0];
        onchip_mem_write_data <= emit_data;
        onchip_mem_byteenable <= be_next;
      end
      if (state == IDLE && onchip_mem_write_start_in) begin
        base_q      <= onchip_mem_start_addr_in[17:5];
        beats_q     <= beats_calc;
        beat_cnt    <= '0;
        last_idx_q  <= words_calc - 32'd1;
        last_lane_q <= tail_sum[4:0] - 5'd1;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
    end
  end

`ifdef ONCHIP_MEM_WR_UNALIGNED_EN
  // Realignment state: offset, flush flag and the previously accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset_q     <= '0;
      need_flush_q <= 1'b0;
      prev_q       <= '0;
    end else if (state == IDLE && onchip_mem_write_start_in) begin
      offset_q     <= start_offset;
      need_flush_q <= (words_calc != beats_calc);
      prev_q       <= '0;
    end else if (accept) begin
      prev_q <= write_data_in;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_write_ctrl.sv
// Testbench for onchip_mem_write_ctrl: directed commands from the reference
// examples, a mid-command reset, then randomized commands with random valid
// gaps. Expected words come from a byte-level placement model.
module tb_onchip_mem_write_ctrl;

  localparam int IW = 302;  // {is_done, addr[12:0], byteenable[31:0], data[255:0]}

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cs, clk_ena, wr;
  logic [12:0]  addr;
  logic [255:0] wdata;
  logic [31:0]  be;
  logic [17:0]  start_addr;
  logic [31:0]  nbytes;
  logic         start;
  logic         done, busy;
  logic [255:0] data_in;
  logic         valid;
  logic         ready;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [IW-1:0] exp_q[$];
  logic [255:0]  beats[$];
  bit mon_en = 1'b0;
  bit last_was_write = 1'b0;

  onchip_mem_write_ctrl dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .onchip_mem_chip_select    (cs),
    .onchip_mem_clk_ena        (clk_ena),
    .onchip_mem_write          (wr),
    .onchip_mem_addr           (addr),
    .onchip_mem_write_data     (wdata),
    .onchip_mem_byteenable     (be),
    .onchip_mem_start_addr_in  (start_addr),
    .to_write_byte_in          (nbytes),
    .onchip_mem_write_start_in (start),
    .onchip_mem_write_done_out (done),
    .busy_out                  (busy),
    .write_data_in             (data_in),
    .write_data_valid_in       (valid),
    .write_ready_out           (ready),
    .dbg_state                 (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: stream byte p lands at byte address start+p. Word i,
  // lane k holds stream position p = 32*i + k - o; lanes before the stream
  // or beyond the supplied beats read as zero, and a lane is enabled only
  // when p lies inside the requested byte count.
  task automatic push_expected(input logic [17:0] sa, input int n);
    int o, b, w, p;
    logic [12:0]  base;
    logic [255:0] d, bt;
    logic [31:0]  m;
`ifdef ONCHIP_MEM_WR_UNALIGNED_EN
    o = int'(sa[4:0]);
`else
    o = 0;
`endif
    base = sa[17:5];
    b = (n + 31) / 32;
    w = (n == 0) ? 0 : (o + n + 31) / 32;
    for (int i = 0; i < w; i++) begin
      d = '0;
      m = '0;
      for (int k = 0; k < 32; k++) begin
        p = i * 32 + k - o;
        if (p >= 0 && p < b * 32) begin
          bt = beats[p / 32];
          d[255 - 8*k -: 8] = bt[255 - 8*(p % 32) -: 8];
        end
        if (p >= 0 && p < n) m[31 - k] = 1'b1;
      end
      exp_q.push_back({1'b0, 13'(base + 13'(i)), m, d});
    end
    exp_q.push_back({1'b1, 13'd0, 32'd0, 255'd0, (n > 0)});
  endtask

  // Scoreboard monitor: pops one expected item per write and per done pulse.
  always @(negedge clk) begin
    logic [IW-1:0] item;
    if (mon_en && rst_n) begin
      if (wr || cs) begin
        check("cs_eq_write", IW'(cs), IW'(wr));
        if (exp_q.size() == 0) begin
          check("unexpected_write", IW'(1), IW'(0));
        end else begin
          item = exp_q.pop_front();
          check("write_word", {1'b0, addr, be, wdata}, item);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", IW'(1), IW'(0));
        end else begin
          item = exp_q.pop_front();
          check("done_pulse", {1'b1, 13'd0, 32'd0, 255'd0, last_was_write}, item);
        end
      end
      last_was_write = wr;
    end else begin
      last_was_write = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, IW'({wr, cs, done, ready, busy, clk_ena}), IW'(6'b000001));
    check({name, "_addr_be"}, IW'({addr, be}), IW'(0));
    check({name, "_data"}, IW'(wdata), IW'(0));
  endtask

  // Driver: issue one command, feed its beats with random valid gaps, then
  // keep offering junk beats until done to prove extra beats are refused.
  task automatic run_cmd(input logic [17:0] sa, input int n);
    int b, sent, extra, cyc;
    bit done_seen;
    b = (n + 31) / 32;
    beats.delete();
    for (int i = 0; i < b; i++) beats.push_back(rand_word());
    push_expected(sa, n);
    start_addr = sa;
    nbytes = 32'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0; extra = 0; cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 2000) begin
      if (sent < b) begin
        valid = ($urandom_range(0, 3) != 0);
        data_in = beats[sent];
      end else begin
        valid = 1'b1;
        data_in = rand_word();
      end
      @(negedge clk);
      cyc++;
      if (done) begin
        done_seen = 1'b1;
        check("busy_in_done", IW'(busy), IW'(1));
      end
      if (valid && ready) begin
        if (sent < b) sent++;
        else extra++;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("done_seen", IW'(done_seen), IW'(1));
    check("beats_taken", IW'(sent), IW'(b));
    check("extra_beats", IW'(extra), IW'(0));
    if (n == 0) check("zero_len_done_latency", IW'(cyc), IW'(1));
    @(negedge clk);
    check("busy_idle", IW'(busy), IW'(0));
    check("cmd_queue_empty", IW'(exp_q.size()), IW'(0));
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // Reset after the first of four writes must stop the command dead.
  task automatic abort_test();
    int sent, bad;
    bit seen;
    mon_en = 1'b0;
    beats.delete();
    for (int i = 0; i < 4; i++) beats.push_back(rand_word());
    start_addr = 18'h00000;
    nbytes = 32'd128;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      valid = 1'b1;
      data_in = beats[(sent < 4) ? sent : 3];
      @(negedge clk);
      seen = wr;
      if (valid && ready) sent++;
      if (seen) break;
      @(posedge clk); #1;
    end
    check("abort_first_write", IW'(seen), IW'(1));
    rst_n = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr || cs || done) bad++;
    end
    check("abort_quiet", IW'(bad), IW'(0));
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    data_in = '0;
    start_addr = '0;
    nbytes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_cmd(18'h00040, 64);   // aligned, two full words
    run_cmd(18'h00005, 64);   // offset 5 (three words when realignment is built in)
    run_cmd(18'h00023, 4);    // short command inside one word
    run_cmd(18'h00100, 0);    // empty command
    run_cmd(18'h3FFE0, 64);   // address wrap
    run_cmd(18'h0001F, 1);    // single byte at last lane
    run_cmd(18'h00001, 31);   // ends exactly at a word boundary
    abort_test();

    for (int t = 0; t < 25; t++) begin
      logic [17:0] sa;
      int n;
      sa = 18'($urandom_range(0, 262143));
      n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 200);
      run_cmd(sa, n);
    end

    repeat (5) @(posedge clk);
    check("final_queue_empty", IW'(exp_q.size()), IW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/onchip_mem_write_ctrl.md
ONCHIP_MEM_WRITE_CTRL -- requirements
Module: onchip_mem_write_ctrl

Interface
REQ-001 SHALL have ports (clk and rst_n first): clk  in  1  sole clock; one clock; reset is synchronous and active-low (rst_n low, sampled on clk rising edge).
REQ-002 SHALL have rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have onchip_mem_chip_select  out 1, onchip_mem_clk_ena  out 1 (constant 1), onchip_mem_write  out 1, onchip_mem_addr  out 13 (256-bit word address).
REQ-004 SHALL have onchip_mem_write_data  out 256 and onchip_mem_byteenable  out 32; byteenable bit (31-k) and data bits [255-8k:248-8k] map to byte offset k in the word.
REQ-005 SHALL have onchip_mem_start_addr_in  in 18 (byte address), to_write_byte_in  in 32 (byte count N), onchip_mem_write_start_in  in 1, onchip_mem_write_done_out  out 1, busy_out  out 1.
REQ-006 SHALL have write_data_in  in 256 (32 stream bytes, stream byte 0 in bits [255:248]), write_data_valid_in  in 1, write_ready_out  out 1.

Function
REQ-007 SHALL use states IDLE, STREAM, FLUSH, DONE; busy_out high outside IDLE.
REQ-008 IDLE: on write_start_in, latch base = start_addr_in[17:5], offset o = start_addr_in[4:0], N; go STREAM (N>0) or DONE (N=0); start outside IDLE ignored.
REQ-009 Beats required B = ceil(N/32); memory words written W = ceil((o+N)/32); 32-bit arithmetic, no overflow for N <= 2^32-33.
REQ-010 write_ready_out high only in STREAM while accepted beats < B; a beat transfers when valid and ready high in the same cycle.
REQ-011 Each accepted beat SHALL produce exactly one write on the next cycle: data = (prev_beat << 8*(32-o)) | (cur_beat >> 8*o), prev_beat zero for the first beat.
REQ-012 Write i (i = 0..W-1) SHALL use addr = base + i, wrapping modulo 8192.
REQ-013 byteenable of write i SHALL be set exactly for lanes whose byte address lies in [start, start+N): first word lanes o..31, last word lanes 0..((o+N-1) mod 32), intersected if first = last, all ones otherwise.
REQ-014 If W = B+1, after last beat's write go FLUSH and issue one write of (prev_beat << 8*(32-o)) with its REQ-013 mask, no beat consumed; else go DONE.
REQ-015 onchip_mem_write and chip_select SHALL be high for exactly W single cycles per command; low otherwise.
REQ-016 DONE: write_done_out high one cycle, return to IDLE next cycle; done SHALL follow the final write by one cycle.
REQ-017 Throughput one beat per clock with valid held high; gaps in valid insert idle cycles with no write.
REQ-018 Beats offered beyond B SHALL not be accepted (ready low).

Reset
REQ-019 On rst_n low: state IDLE, write/chip_select/done/ready/busy 0, addr 0, write_data 0, byteenable 0, prev_beat 0, counters 0; clk_ena remains 1.
REQ-020 Reset mid-command SHALL abort immediately: no further writes, no done pulse.

Configuration
REQ-021 Macro ONCHIP_MEM_WR_UNALIGNED_EN defined: arbitrary offset o per REQ-011..014.
REQ-022 Macro undefined: start_addr_in[4:0] ignored, o treated as 0, no shifter or prev_beat register, FLUSH never entered, W = B.

Verification
REQ-023 Aligned: start 0x00040, N=64, 2 beats -> writes addr 0x002,0x003, byteenable 0xFFFFFFFF both, done 1 cycle after second write.
REQ-024 Unaligned (macro on): start 0x00005, N=64 -> 3 writes addr 0,1,2, masks 0x07FFFFFF, 0xFFFFFFFF, 0xF8000000, third via FLUSH.
REQ-025 Short: start 0x00023 (o=3), N=4 -> 1 write addr 0x001, mask 0x1E000000, data lanes 3..6 = stream bytes 0..3.
REQ-026 N=0 -> no write, ready never high, done 1 cycle after start.
REQ-027 Wrap: start 0x3FFE0, N=64 -> writes addr 0x1FFF then 0x0000.
REQ-028 Reset asserted after first of 4 writes -> no further writes, no done, all outputs at REQ-019 values next cycle.
